// File: rtl/latency_mem.sv
// Multi-channel memory model: every channel has its own read and write FSM with
// a fixed accept-to-ready latency, plus a backdoor port for preload and inspection.
module latency_mem #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CHANNELS-1:0]            read_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] read_addr,
  output logic [NUM_CHANNELS-1:0]            read_ready,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] read_data,
  input  logic [NUM_CHANNELS-1:0]            write_valid,
  input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] write_data,
  output logic [NUM_CHANNELS-1:0]            write_ready,
  input  logic                               bd_we,
  input  logic [ADDR_WIDTH-1:0]              bd_addr,
  input  logic [DATA_WIDTH-1:0]              bd_wdata,
  output logic [DATA_WIDTH-1:0]              bd_rdata,
  output logic                               addr_err
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WRITE_LATENCY - 1);
  localparam logic [32:0] DEPTH_W = 33'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP,
    ST_DRAIN
  } state_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 33'(a) < DEPTH_W;
  endfunction

  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0]            wr_commit;
  logic [NUM_CHANNELS*IDX_W-1:0]      wr_idx;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] wr_word;
  logic [2*NUM_CHANNELS-1:0]          err_hit;
  logic                               addr_err_q, addr_err_d;
  logic                               bd_ok;
  logic [IDX_W-1:0]                   bd_idx;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t                  rd_state_q, rd_state_d;
    logic [3:0]              rd_cnt_q, rd_cnt_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_ok, rd_ready_o;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_data_o;

    state_t                  wr_state_q, wr_state_d;
    logic [3:0]              wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_ok, wr_ready_o, wr_commit_o;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_state_q <= ST_IDLE;
        rd_cnt_q   <= '0;
        rd_addr_q  <= '0;
      end else begin
        rd_state_q <= rd_state_d;
        rd_cnt_q   <= rd_cnt_d;
        rd_addr_q  <= rd_addr_d;
      end
    end

    always_comb begin
      rd_state_d = rd_state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_addr_d  = rd_addr_q;
      unique case (rd_state_q)
        ST_IDLE: begin
          if (read_valid[c]) begin
            rd_addr_d  = read_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            rd_cnt_d   = RD_LOAD;
            rd_state_d = (READ_LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Leaving when the count reaches zero keeps BUSY at LATENCY-1 cycles.
          rd_cnt_d = rd_cnt_q - 4'd1;
          if (rd_cnt_q <= 4'd1) rd_state_d = ST_RESP;
        end
        ST_RESP:  rd_state_d = read_valid[c] ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (!read_valid[c]) rd_state_d = ST_IDLE;
        default:  rd_state_d = ST_IDLE;
      endcase
    end

    assign rd_ok  = in_range(rd_addr_q);
    assign rd_idx = rd_addr_q[IDX_W-1:0];

    always_comb begin
      rd_ready_o = (rd_state_q == ST_RESP);
      rd_data_o  = '0;
      if (rd_ready_o && rd_ok) rd_data_o = mem_q[rd_idx];
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_state_q <= ST_IDLE;
        wr_cnt_q   <= '0;
        wr_addr_q  <= '0;
        wr_data_q  <= '0;
      end else begin
        wr_state_q <= wr_state_d;
        wr_cnt_q   <= wr_cnt_d;
        wr_addr_q  <= wr_addr_d;
        wr_data_q  <= wr_data_d;
      end
    end

    always_comb begin
      wr_state_d = wr_state_q;
      wr_cnt_d   = wr_cnt_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      unique case (wr_state_q)
        ST_IDLE: begin
          if (write_valid[c]) begin
            wr_addr_d  = write_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_d  = write_data[c*DATA_WIDTH +: DATA_WIDTH];
            wr_cnt_d   = WR_LOAD;
            wr_state_d = (WRITE_LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          wr_cnt_d = wr_cnt_q - 4'd1;
          if (wr_cnt_q <= 4'd1) wr_state_d = ST_RESP;
        end
        ST_RESP:  wr_state_d = write_valid[c] ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (!write_valid[c]) wr_state_d = ST_IDLE;
        default:  wr_state_d = ST_IDLE;
      endcase
    end

    assign wr_ok = in_range(wr_addr_q);

    always_comb begin
      wr_ready_o  = (wr_state_q == ST_RESP);
      wr_commit_o = wr_ready_o && wr_ok;
    end

    assign read_ready[c]                         = rd_ready_o;
    assign read_data[c*DATA_WIDTH +: DATA_WIDTH] = rd_data_o;
    assign write_ready[c]                        = wr_ready_o;
    assign wr_commit[c]                          = wr_commit_o;
    assign wr_idx[c*IDX_W +: IDX_W]              = wr_addr_q[IDX_W-1:0];
    assign wr_word[c*DATA_WIDTH +: DATA_WIDTH]   = wr_data_q;
    assign err_hit[2*c]                          = rd_ready_o && !rd_ok;
    assign err_hit[2*c+1]                        = wr_ready_o && !wr_ok;
  end

  // ---------------- storage ----------------
  assign bd_ok    = in_range(bd_addr);
  assign bd_idx   = bd_addr[IDX_W-1:0];
  assign bd_rdata = bd_ok ? mem_q[bd_idx] : '0;

  // No reset on the array; later assignments win, so the backdoor loses to any
  // channel and higher channel indices override lower ones.
  always_ff @(posedge clk) begin
    if (bd_we && bd_ok) mem_q[bd_idx] <= bd_wdata;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (wr_commit[ch]) mem_q[wr_idx[ch*IDX_W +: IDX_W]] <= wr_word[ch*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------- sticky error ----------------
  always_comb begin
    addr_err_d = addr_err_q | (|err_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= addr_err_d;
  end

  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_latency_mem.sv
// Scoreboard bench for latency_mem: instance A (DEPTH=128, 2/2 latency) and
// instance B (DEPTH=256, read latency 1, write latency 5).
module tb_latency_mem;

  typedef struct {
    int         due;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t       rq [2][4][$];
  exp_t       wq [2][4][$];
  logic [7:0] mdl [2][256];
  int         dep [2] = '{128, 256};
  int         rlat [2] = '{2, 1};
  int         wlat [2] = '{2, 5};

  logic [3:0]  a_rv, a_wv, a_rr, a_wr, b_rv, b_wv, b_rr, b_wr;
  logic [31:0] a_ra, a_wa, a_wd, a_rd, b_ra, b_wa, b_wd, b_rd;
  logic        a_bwe, a_err, b_bwe, b_err;
  logic [7:0]  a_ba, a_bwd, a_bd, b_ba, b_bwd, b_bd;

  latency_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CHANNELS(4), .DEPTH(128),
                .READ_LATENCY(2), .WRITE_LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .read_valid(a_rv), .read_addr(a_ra), .read_ready(a_rr), .read_data(a_rd),
    .write_valid(a_wv), .write_addr(a_wa), .write_data(a_wd), .write_ready(a_wr),
    .bd_we(a_bwe), .bd_addr(a_ba), .bd_wdata(a_bwd), .bd_rdata(a_bd), .addr_err(a_err));

  latency_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CHANNELS(4), .DEPTH(256),
                .READ_LATENCY(1), .WRITE_LATENCY(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_valid(b_rv), .read_addr(b_ra), .read_ready(b_rr), .read_data(b_rd),
    .write_valid(b_wv), .write_addr(b_wa), .write_data(b_wd), .write_ready(b_wr),
    .bd_we(b_bwe), .bd_addr(b_ba), .bd_wdata(b_bwd), .bd_rdata(b_bd), .addr_err(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input int i, input logic [3:0] rr, input logic [31:0] rd, input logic [3:0] wr);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (rr[c]) begin
        if (rq[i][c].size() == 0) chk("rd_extra_pulse", 32'(rr[c]), 0);
        else begin
          e = rq[i][c].pop_front();
          chk("rd_cycle", cyc, e.due);
          chk("rd_data", 32'(rd[c*8 +: 8]), 32'(e.data));
        end
      end else begin
        chk("rd_data_idle", 32'(rd[c*8 +: 8]), 0);
        if (rq[i][c].size() != 0 && rq[i][c][0].due < cyc) begin
          chk("rd_missing", 32'(rr[c]), 1);
          void'(rq[i][c].pop_front());
        end
      end
      if (wr[c]) begin
        if (wq[i][c].size() == 0) chk("wr_extra_pulse", 32'(wr[c]), 0);
        else begin
          e = wq[i][c].pop_front();
          chk("wr_cycle", cyc, e.due);
        end
      end else if (wq[i][c].size() != 0 && wq[i][c][0].due < cyc) begin
        chk("wr_missing", 32'(wr[c]), 1);
        void'(wq[i][c].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_rr, a_rd, a_wr);
    mon(1, b_rr, b_rd, b_wr);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd_go(input int i, input int c, input logic [7:0] addr);
    exp_t e;
    e.due  = cyc + rlat[i];
    e.data = (int'(addr) < dep[i]) ? mdl[i][addr] : 8'h00;
    rq[i][c].push_back(e);
    if (i == 0) begin a_rv[c] = 1'b1; a_ra[c*8 +: 8] = addr; end
    else        begin b_rv[c] = 1'b1; b_ra[c*8 +: 8] = addr; end
  endtask

  task automatic wr_go(input int i, input int c, input logic [7:0] addr, input logic [7:0] data);
    exp_t e;
    e.due  = cyc + wlat[i];
    e.data = data;
    wq[i][c].push_back(e);
    if (int'(addr) < dep[i]) mdl[i][addr] = data;
    if (i == 0) begin a_wv[c] = 1'b1; a_wa[c*8 +: 8] = addr; a_wd[c*8 +: 8] = data; end
    else        begin b_wv[c] = 1'b1; b_wa[c*8 +: 8] = addr; b_wd[c*8 +: 8] = data; end
  endtask

  task automatic bd_wr(input int i, input logic [7:0] addr, input logic [7:0] data);
    mdl[i][addr] = data;
    if (i == 0) begin a_bwe = 1'b1; a_ba = addr; a_bwd = data; end
    else        begin b_bwe = 1'b1; b_ba = addr; b_bwd = data; end
    tick();
    a_bwe = 1'b0;
    b_bwe = 1'b0;
  endtask

  task automatic bd_chk(input int i, input string tag, input logic [7:0] addr, input logic [7:0] exp);
    if (i == 0) a_ba = addr; else b_ba = addr;
    #1;
    chk(tag, (i == 0) ? 32'(a_bd) : 32'(b_bd), 32'(exp));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_a_rr"}, 32'(a_rr), 0);
    chk({tag, "_a_wr"}, 32'(a_wr), 0);
    chk({tag, "_a_rd"}, a_rd, 0);
    chk({tag, "_a_err"}, 32'(a_err), 0);
    chk({tag, "_b_rr"}, 32'(b_rr), 0);
    chk({tag, "_b_wr"}, 32'(b_wr), 0);
    chk({tag, "_b_err"}, 32'(b_err), 0);
  endtask

  initial begin
    a_rv = '0; a_wv = '0; a_ra = '0; a_wa = '0; a_wd = '0; a_bwe = 1'b0; a_ba = '0; a_bwd = '0;
    b_rv = '0; b_wv = '0; b_ra = '0; b_wa = '0; b_wd = '0; b_bwe = 1'b0; b_ba = '0; b_bwd = '0;
    #3 rst_n = 1'b0;
    tick(); tick();
    chk_quiet("reset");
    rst_n = 1'b1;
    tick();

    // Backdoor preload then single read with latency 2.
    bd_wr(0, 8'd3, 8'h2A);
    bd_chk(0, "bd_addr3", 8'd3, 8'h2A);
    rd_go(0, 0, 8'd3);
    tick();
    a_rv = '0;
    a_ra[7:0] = 8'h7F;
    repeat (4) tick();

    // All four channels write 16..19 with valid held five cycles.
    for (int c = 0; c < 4; c++) wr_go(0, c, 8'(16 + c), 8'h07);
    repeat (5) tick();
    a_wv = '0;
    repeat (3) tick();
    for (int c = 0; c < 4; c++) bd_chk(0, "bulk_write", 8'(16 + c), 8'h07);

    // Same-address write collision, read-vs-commit, channel-vs-backdoor.
    rd_go(0, 0, 8'h10);
    wr_go(0, 1, 8'h10, 8'h11);
    wr_go(0, 3, 8'h10, 8'h33);
    wr_go(0, 2, 8'h20, 8'h55);
    tick();
    a_rv = '0; a_wv = '0;
    tick();
    a_bwe = 1'b1; a_ba = 8'h20; a_bwd = 8'h66;
    tick();
    a_bwe = 1'b0;
    repeat (3) tick();
    bd_chk(0, "hi_chan_wins", 8'h10, 8'h33);
    bd_chk(0, "chan_beats_bd", 8'h20, 8'h55);

    // Out-of-range read and write on DEPTH=128.
    bd_wr(0, 8'd2, 8'h5A);
    chk("err_before", 32'(a_err), 0);
    rd_go(0, 2, 8'd200);
    wr_go(0, 1, 8'd130, 8'hEE);
    tick();
    a_rv = '0; a_wv = '0;
    repeat (5) tick();
    chk("err_set", 32'(a_err), 1);
    bd_chk(0, "oob_write_dropped", 8'd2, 8'h5A);
    repeat (3) tick();
    chk("err_sticky", 32'(a_err), 1);

    // Reset in the middle of a write's BUSY phase aborts it.
    bd_wr(0, 8'd5, 8'h44);
    a_wv[0] = 1'b1; a_wa[7:0] = 8'd5; a_wd[7:0] = 8'h99;
    tick();
    a_wv = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin rq[i][c].delete(); wq[i][c].delete(); end
    #1;
    chk_quiet("mid_reset");
    repeat (3) tick();
    chk_quiet("held_reset");
    bd_chk(0, "array_kept", 8'd5, 8'h44);
    rst_n = 1'b1;
    rd_go(0, 0, 8'd5);
    tick();
    a_rv = '0;
    repeat (4) tick();

    // Instance B: read latency 1 toggled, write latency 5 pulsed.
    bd_wr(1, 8'd8, 8'h81);
    bd_wr(1, 8'd9, 8'h92);
    bd_wr(1, 8'h41, 8'h00);
    for (int k = 0; k < 4; k++) begin
      rd_go(1, 0, (k % 2 == 1) ? 8'd9 : 8'd8);
      tick();
      b_rv = '0;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      wr_go(1, 1, 8'(8'h30 + k), 8'(8'hC0 + k));
      tick();
      b_wv = '0;
      repeat (5) tick();
    end
    for (int k = 0; k < 3; k++) bd_chk(1, "lat5_write", 8'(8'h30 + k), 8'(8'hC0 + k));

    // Held valid with changing address/data: captured values only, one pulse.
    wr_go(1, 2, 8'h40, 8'hA5);
    rd_go(1, 3, 8'd9);
    for (int k = 0; k < 7; k++) begin
      tick();
      b_wa[23:16] = 8'h41;
      b_wd[23:16] = 8'(8'h5A + k);
      b_ra[31:24] = 8'd8;
    end
    b_wv = '0; b_rv = '0;
    repeat (4) tick();
    bd_chk(1, "held_captured", 8'h40, 8'hA5);
    bd_chk(1, "held_ignored", 8'h41, 8'h00);

    repeat (6) tick();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) begin
        chk("rd_leftover", rq[i][c].size(), 0);
        chk("wr_leftover", wq[i][c].size(), 0);
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/latency_mem.md
LATENCY_MEM -- requirements
Module: latency_mem

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 8, request address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL provide parameter NUM_CHANNELS, default 4, number of independent request channels.
REQ-004 SHALL provide parameter DEPTH, default 256, words of storage; DEPTH <= 2**ADDR_WIDTH.
REQ-005 SHALL provide parameters READ_LATENCY and WRITE_LATENCY, default 2 each, range 1..15, cycles from accept to ready.
REQ-006 SHALL provide: clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-008 SHALL provide: read_valid  in  NUM_CHANNELS  per-channel read request.
REQ-009 SHALL provide: read_addr  in  NUM_CHANNELS x ADDR_WIDTH  per-channel read address.
REQ-010 SHALL provide: read_ready  out  NUM_CHANNELS  one-cycle read completion pulse.
REQ-011 SHALL provide: read_data  out  NUM_CHANNELS x DATA_WIDTH  read result, valid while read_ready high.
REQ-012 SHALL provide: write_valid, write_addr, write_data  in  NUM_CHANNELS / x ADDR_WIDTH / x DATA_WIDTH  per-channel write request.
REQ-013 SHALL provide: write_ready  out  NUM_CHANNELS  one-cycle write completion pulse.
REQ-014 SHALL provide: bd_we  in  1, bd_addr  in  ADDR_WIDTH, bd_wdata  in  DATA_WIDTH, bd_rdata  out  DATA_WIDTH  backdoor preload/inspect port.
REQ-015 SHALL provide: addr_err  out  1  sticky out-of-range flag.

Function
REQ-016 Each channel SHALL have separate read and write FSMs, states IDLE, BUSY, RESP, DRAIN.
REQ-017 IDLE: valid high at a rising edge SHALL accept the request, capture addr (and data), load counter with LATENCY-1, go to BUSY.
REQ-018 BUSY: counter SHALL decrement each cycle; at zero go to RESP; with LATENCY=1, BUSY SHALL last zero cycles (IDLE->RESP directly).
REQ-019 RESP: ready SHALL be high exactly one cycle, LATENCY cycles after the accepting edge; read_data driven from the array in this cycle; write committed at the end of this cycle.
REQ-020 After RESP, if valid still high, go to DRAIN and stay until valid low, then IDLE; if valid low, go directly to IDLE; a held valid SHALL never be accepted twice.
REQ-021 Address, data and valid changes while BUSY/RESP SHALL be ignored (captured values used).
REQ-022 read_data SHALL be zero outside RESP.
REQ-023 Two channel writes committing the same address in the same cycle: highest channel index SHALL win.
REQ-024 Read RESP and write commit to the same address in the same cycle: read SHALL return the pre-write value.
REQ-025 Channel write commit and bd_we to the same address in the same cycle: channel write SHALL win.
REQ-026 bd_we SHALL write bd_wdata at the rising edge; bd_rdata SHALL be the combinational array content at bd_addr.
REQ-027 Address >= DEPTH: read SHALL return zero, write SHALL be dropped, handshake timing unchanged, addr_err set at RESP and held until reset.
REQ-028 Channels SHALL be fully independent; no cross-channel stall or arbitration.

Reset
REQ-029 rst_n low SHALL immediately force all FSMs to IDLE, counters 0, read_ready/write_ready 0, read_data 0, addr_err 0.
REQ-030 Reset SHALL NOT clear array contents; in-flight writes aborted by reset SHALL NOT commit.
REQ-031 First acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-032 bd preload addr 3=0x2A; ch0 read addr 3, READ_LATENCY=2 -> read_ready ch0 pulses one cycle, 2 cycles after accept, read_data=0x2A, then 0.
REQ-033 All 4 channels write addr 16..19 = 7 simultaneously, valid held 5 cycles -> one write_ready pulse each, bd_rdata 16..19 = 7, no second commit.
REQ-034 ch1 and ch3 write addr 0x10 values 0x11/0x33 same cycle -> addr 0x10 = 0x33; ch0 read of 0x10 completing same cycle returns old value.
REQ-035 DEPTH=128, ch2 read addr 200 -> read_ready after latency, read_data=0, addr_err=1 until reset.
REQ-036 ch0 write accepted, rst_n pulsed low mid-BUSY -> no write_ready, address unchanged, all outputs 0 during reset.
REQ-037 READ_LATENCY=1, WRITE_LATENCY=5 back-to-back toggled requests -> ready exactly 1 and 5 cycles after each accept.
